// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - serial N-bit pattern detector, Mealy/Moore output, overlap select
// Optional match counter enabled by defining PATTERN_DETECTOR_COUNT_EN.
module pattern_detector #(
  parameter int             N             = 3,
  parameter logic [N-1:0]   RESET_PATTERN = 3'b101,
  parameter bit             MOORE         = 1'b0,
  parameter int             CW            = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in,
  input  logic         cfg_load,
  input  logic [N-1:0] cfg_pattern,
  input  logic         cfg_overlap,
  output logic         out,
  output logic         busy
`ifdef PATTERN_DETECTOR_COUNT_EN
  ,
  output logic [CW-1:0] match_count
`endif
);

  localparam int FW = $clog2(N + 1);

  if (N < 2 || N > 16 || CW < 1) begin : g_bad_params
    $error("pattern_detector: N must be 2..16 and CW at least 1");
  end

  logic [N-1:0]  history;
  logic [N-1:0]  pattern;
  logic [FW-1:0] fill;
  logic          overlap;
  logic          out_q;
  logic [N-1:0]  candidate;
  logic          match;

  assign candidate = {history[N-2:0], in};

  // The current bit counts toward the fill, so N-1 stored bits suffice.
  assign match = in_valid && !cfg_load && (fill >= FW'(N - 1)) && (candidate == pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
      pattern <= RESET_PATTERN;
      overlap <= 1'b1;
    end else if (cfg_load) begin
      history <= '0;
      fill    <= '0;
      pattern <= cfg_pattern;
      overlap <= cfg_overlap;
    end else if (in_valid) begin
      history <= candidate;
      if (match && !overlap) begin
        fill <= '0;
      end else if (fill != FW'(N)) begin
        fill <= fill + FW'(1);
      end
    end
  end

  // Moore output is a one-cycle pulse following the matching bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 1'b0;
    end else begin
      out_q <= match;
    end
  end

  assign out  = MOORE ? out_q : match;
  assign busy = (fill != '0);

`ifdef PATTERN_DETECTOR_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count <= '0;
    end else if (cfg_load) begin
      match_count <= '0;
    end else if (match && (match_count != {CW{1'b1}})) begin
      match_count <= match_count + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// tb/tb_pattern_detector.sv - directed self-checking bench for pattern_detector
module tb_pattern_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;
  logic       cfg_load = 1'b0;
  logic [2:0] cfg_pattern3 = 3'b000;
  logic [3:0] cfg_pattern4 = 4'b0000;
  logic       cfg_overlap = 1'b1;

  logic out, busy, out_m, busy_m, out4, busy4, out_c, busy_c;
`ifdef PATTERN_DETECTOR_COUNT_EN
  logic [7:0] mc, mc_m, mc4;
  logic [1:0] mc_c;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pattern_detector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern3), .cfg_overlap(cfg_overlap), .out(out), .busy(busy)
`ifdef PATTERN_DETECTOR_COUNT_EN
    , .match_count(mc)
`endif
  );

  pattern_detector #(.MOORE(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern3), .cfg_overlap(cfg_overlap), .out(out_m), .busy(busy_m)
`ifdef PATTERN_DETECTOR_COUNT_EN
    , .match_count(mc_m)
`endif
  );

  pattern_detector #(.N(4), .RESET_PATTERN(4'b1101)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern4), .cfg_overlap(cfg_overlap), .out(out4), .busy(busy4)
`ifdef PATTERN_DETECTOR_COUNT_EN
    , .match_count(mc4)
`endif
  );

  pattern_detector #(.CW(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern3), .cfg_overlap(cfg_overlap), .out(out_c), .busy(busy_c)
`ifdef PATTERN_DETECTOR_COUNT_EN
    , .match_count(mc_c)
`endif
  );

  // Present one input cycle; returns 1 ns later so combinational outputs are settled.
  task automatic put(input logic v, input logic b);
    @(negedge clk);
    in_valid = v;
    in       = b;
    cfg_load = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    put(1'b1, 1'b1);
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL reset_pre_busy: got %b expected 1", busy); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_async_busy: got %b expected 0", busy); else passed++;
    checks++; if (busy4 !== 1'b0) $display("FAIL reset_async_busy4: got %b expected 0", busy4); else passed++;
    checks++; if (out !== 1'b0) $display("FAIL reset_out: got %b expected 0", out); else passed++;
    checks++; if (out_m !== 1'b0) $display("FAIL reset_out_moore: got %b expected 0", out_m); else passed++;
`ifdef PATTERN_DETECTOR_COUNT_EN
    checks++; if (mc !== 8'd0) $display("FAIL reset_count: got %0d expected 0", mc); else passed++;
`endif
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_overlap();
    logic s[5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic exp[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      put(1'b1, s[i]);
      checks++; if (out !== exp[i]) $display("FAIL overlap_out[%0d]: got %b expected %b", i, out, exp[i]); else passed++;
    end
    put(1'b0, 1'b1);
    checks++; if (out !== 1'b0) $display("FAIL overlap_idle_out: got %b expected 0", out); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL overlap_busy: got %b expected 1", busy); else passed++;
`ifdef PATTERN_DETECTOR_COUNT_EN
    checks++; if (mc !== 8'd2) $display("FAIL overlap_count: got %0d expected 2", mc); else passed++;
`endif
  endtask

  task automatic test_non_overlap();
    logic s[5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic exp[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    put(1'b1, 1'b1);
    put(1'b1, 1'b0);
    @(negedge clk);
    cfg_load     = 1'b1;
    cfg_pattern3 = 3'b101;
    cfg_overlap  = 1'b0;
    in_valid     = 1'b1;
    in           = 1'b1;
    #1;
    checks++; if (out !== 1'b0) $display("FAIL cfg_load_suppress: got %b expected 0", out); else passed++;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, s[i]);
      if (i == 0) begin
        checks++; if (busy !== 1'b0) $display("FAIL cfg_load_cleared_busy: got %b expected 0", busy); else passed++;
      end
      checks++; if (out !== exp[i]) $display("FAIL nonoverlap_out[%0d]: got %b expected %b", i, out, exp[i]); else passed++;
    end
    put(1'b0, 1'b0);
`ifdef PATTERN_DETECTOR_COUNT_EN
    checks++; if (mc !== 8'd1) $display("FAIL nonoverlap_count: got %0d expected 1", mc); else passed++;
`endif
    cfg_overlap = 1'b1;
  endtask

  task automatic test_moore();
    logic s[3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put(1'b1, s[i]);
      checks++; if (out_m !== 1'b0) $display("FAIL moore_early[%0d]: got %b expected 0", i, out_m); else passed++;
    end
    put(1'b0, 1'b0);
    checks++; if (out_m !== 1'b1) $display("FAIL moore_pulse: got %b expected 1", out_m); else passed++;
    put(1'b0, 1'b0);
    checks++; if (out_m !== 1'b0) $display("FAIL moore_pulse_end: got %b expected 0", out_m); else passed++;
  endtask

  task automatic test_gaps();
    logic v[10]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic d[10]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic eo[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      put(v[i], d[i]);
      checks++; if (out4 !== eo[i]) $display("FAIL gaps_out[%0d]: got %b expected %b", i, out4, eo[i]); else passed++;
      checks++; if (busy4 !== (i != 0)) $display("FAIL gaps_busy[%0d]: got %b expected %b", i, busy4, (i != 0)); else passed++;
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    put(1'b1, 1'b1);
    put(1'b1, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in       = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else passed++;
    checks++; if (out !== 1'b0) $display("FAIL rst_mid_out: got %b expected 0", out); else passed++;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rst_hold_busy: got %b expected 0", busy); else passed++;
    rst = 1'b0;
    put(1'b1, 1'b1);
    checks++; if (out !== 1'b0) $display("FAIL rst_mid_nomatch: got %b expected 0", out); else passed++;
  endtask

  task automatic test_saturate();
    int hits = 0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      put(1'b1, (i % 2 == 0));
      if (out_c === 1'b1) hits++;
    end
    put(1'b0, 1'b0);
    checks++; if (hits !== 5) $display("FAIL sat_matches: got %0d expected 5", hits); else passed++;
`ifdef PATTERN_DETECTOR_COUNT_EN
    checks++; if (mc_c !== 2'd3) $display("FAIL sat_count: got %0d expected 3", mc_c); else passed++;
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_moore();
    test_gaps();
    test_rst_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
